// File: rtl/key_lock_pkg.sv
// Shared definitions for the key-locked c432 front end: key field widths,
// derived key/counter widths and the loader state encoding.
package key_lock_pkg;

  localparam int MUX_KEY_W_DEF = 4;
  localparam int XOR_KEY_W_DEF = 11;
  localparam int KEY_W         = MUX_KEY_W_DEF + XOR_KEY_W_DEF;
  localparam int KEY_CNT_W     = $clog2(KEY_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_CHECK,
    ST_LOCKED,
    ST_BLOCKED
  } state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Serial key shadow register: captures key bits LSB-first, counts them and
// accumulates their XOR together with the trailing parity bit.
module key_shift_reg
  import key_lock_pkg::*;
#(
  parameter int KEY_W_P = KEY_W,
  parameter int CNT_W   = $clog2(KEY_W_P)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_shift_en,
  input  logic               i_parity_en,
  input  logic               i_bit,
  output logic [KEY_W_P-1:0] o_shadow,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_parity
);

  logic [KEY_W_P-1:0] r_shadow;
  logic [CNT_W-1:0]   r_count;
  logic               r_parity;

  // Shadow fill, bit counter and parity accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else if (i_clear) begin
      r_shadow <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else if (i_shift_en) begin
      r_shadow[r_count] <= i_bit;
      r_count           <= r_count + CNT_W'(1);
      r_parity          <= r_parity ^ i_bit;
    end else if (i_parity_en) begin
      r_parity <= r_parity ^ i_bit;
    end
  end

  assign o_shadow = r_shadow;
  assign o_count  = r_count;
  assign o_parity = r_parity;

endmodule

// File: rtl/key_serial_loader.sv
// Serial unlock-key loader: receives the key plus an even-parity bit over a
// valid/ready handshake, commits it to held key registers on a good check,
// and permanently blocks after MAX_TRIES parity failures.
module key_serial_loader
  import key_lock_pkg::*;
#(
  parameter int MUX_KEY_W = key_lock_pkg::MUX_KEY_W_DEF,
  parameter int XOR_KEY_W = key_lock_pkg::XOR_KEY_W_DEF,
  parameter int MAX_TRIES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 bit_ready,
  output logic [MUX_KEY_W-1:0] mux_key,
  output logic [XOR_KEY_W-1:0] xor_key,
  output logic                 key_loaded,
  output logic                 key_error,
  output logic                 blocked,
  output logic                 busy
);

  localparam int KW      = MUX_KEY_W + XOR_KEY_W;
  localparam int CNT_W   = $clog2(KW);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  state_t               r_state;
  logic                 r_bit_ready;
  logic                 r_busy;
  logic                 r_blocked;
  logic                 r_key_loaded;
  logic                 r_key_error;
  logic [MUX_KEY_W-1:0] r_mux_key;
  logic [XOR_KEY_W-1:0] r_xor_key;
  logic [TRIES_W-1:0]   r_tries;

  logic                 w_xfer;
  logic                 w_clear;
  logic                 w_shift_en;
  logic                 w_parity_en;
  logic                 w_last;
  logic [KW-1:0]        w_shadow;
  logic [CNT_W-1:0]     w_count;
  logic                 w_parity;

  assign w_xfer      = bit_valid & r_bit_ready;
  assign w_clear     = ((r_state == ST_IDLE) & load_start) | (r_state == ST_BLOCKED);
  assign w_shift_en  = w_xfer & (r_state == ST_SHIFT);
  assign w_parity_en = w_xfer & (r_state == ST_PARITY);
  assign w_last      = (w_count == CNT_W'(KW - 1));

  key_shift_reg #(
    .KEY_W_P (KW),
    .CNT_W   (CNT_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_shift_en  (w_shift_en),
    .i_parity_en (w_parity_en),
    .i_bit       (bit_data),
    .o_shadow    (w_shadow),
    .o_count     (w_count),
    .o_parity    (w_parity)
  );

  // Load FSM; ready/busy/blocked are registered alongside each state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_blocked    <= 1'b0;
      r_key_loaded <= 1'b0;
      r_key_error  <= 1'b0;
      r_mux_key    <= '0;
      r_xor_key    <= '0;
      r_tries      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state     <= ST_SHIFT;
            r_bit_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_key_error <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_xfer && w_last) begin
            r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (w_xfer) begin
            r_state     <= ST_CHECK;
            r_bit_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          if (!w_parity) begin
            r_mux_key    <= w_shadow[MUX_KEY_W-1:0];
            r_xor_key    <= w_shadow[KW-1:MUX_KEY_W];
            r_key_loaded <= 1'b1;
            r_state      <= ST_LOCKED;
          end else begin
            r_key_error <= 1'b1;
            r_tries     <= r_tries + TRIES_W'(1);
            if (r_tries == TRIES_W'(MAX_TRIES - 1)) begin
              r_state   <= ST_BLOCKED;
              r_blocked <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_LOCKED: begin
          r_state <= ST_LOCKED;
        end
        ST_BLOCKED: begin
          r_mux_key <= '0;
          r_xor_key <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_bit_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready  = r_bit_ready;
  assign busy       = r_busy;
  assign blocked    = r_blocked;
  assign key_loaded = r_key_loaded;
  assign key_error  = r_key_error;
  assign mux_key    = r_mux_key;
  assign xor_key    = r_xor_key;

endmodule

// File: tb/tb_key_serial_loader.sv
// Bench for key_serial_loader: directed vector table for the scenarios of
// interest, hand-written async-reset sequence, then randomized loads checked
// against an abstract model of the loader's observable rules.
module tb_key_serial_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_ready;
  logic [3:0]  mux_key;
  logic [10:0] xor_key;
  logic        key_loaded;
  logic        key_error;
  logic        blocked;
  logic        busy;

  int n_pass;
  int n_total;

  key_serial_loader #(
    .MUX_KEY_W (4),
    .XOR_KEY_W (11),
    .MAX_TRIES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_ready  (bit_ready),
    .mux_key    (mux_key),
    .xor_key    (xor_key),
    .key_loaded (key_loaded),
    .key_error  (key_error),
    .blocked    (blocked),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the outputs should show once the loader has settled.
  logic [3:0]  m_mux;
  logic [10:0] m_xor;
  logic        m_loaded;
  logic        m_error;
  logic        m_blocked;
  int          m_tries;

  typedef struct {
    logic        do_reset;
    logic [14:0] key;
    logic        par;
    int          gap_mode;
    logic        mid_start;
    logic        exp_ready;
    logic [3:0]  exp_mux;
    logic [10:0] exp_xor;
    logic        exp_loaded;
    logic        exp_error;
    logic        exp_blocked;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mux = '0; m_xor = '0; m_loaded = 1'b0; m_error = 1'b0;
    m_blocked = 1'b0; m_tries = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_bit(input logic b, input logic start_too, input logic exp_ready);
    @(negedge clk);
    bit_valid  = 1'b1;
    bit_data   = b;
    load_start = start_too;
    check("bit_ready", {31'd0, bit_ready}, {31'd0, exp_ready});
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_data  = 1'($urandom);
    end
  endtask

  // Full attempt: start pulse, 15 key bits LSB-first, parity bit, two settle edges.
  task automatic run_load(input logic [14:0] key, input logic par, input int gap_mode,
                          input logic mid_start, input logic exp_ready);
    logic [15:0] stream;
    stream = {par, key};
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_bit(stream[i], mid_start && (i == 5), exp_ready);
      if (gap_mode == 1) idle_cycles(2);
      else if (gap_mode == 2) idle_cycles(int'($urandom_range(0, 3)));
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs(input logic [3:0] e_mux, input logic [10:0] e_xor,
                               input logic e_loaded, input logic e_error, input logic e_blocked);
    check("mux_key",    {28'd0, mux_key},    {28'd0, e_mux});
    check("xor_key",    {21'd0, xor_key},    {21'd0, e_xor});
    check("key_loaded", {31'd0, key_loaded}, {31'd0, e_loaded});
    check("key_error",  {31'd0, key_error},  {31'd0, e_error});
    check("blocked",    {31'd0, blocked},    {31'd0, e_blocked});
    check("busy",       {31'd0, busy},       32'd0);
    check("bit_ready_idle", {31'd0, bit_ready}, 32'd0);
  endtask

  // Abstract rules: loads are accepted unless locked or blocked; even overall
  // parity commits, odd parity counts a try and blocks on the third.
  task automatic model_load(input logic [14:0] key, input logic par);
    if (m_loaded || m_blocked) return;
    if ((^key ^ par) == 1'b0) begin
      m_mux = key[3:0]; m_xor = key[14:4]; m_loaded = 1'b1; m_error = 1'b0;
    end else begin
      m_error = 1'b1;
      m_tries++;
      if (m_tries >= 3) m_blocked = 1'b1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; load_start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    n_pass = 0; n_total = 0;
    model_reset();

    //        rst   key       par  gap mid  rdy  mux   xor      ld   err  blk
    vecs.push_back('{1'b1, 15'h5A3C, 1'b0, 0, 1'b0, 1'b1, 4'hC, 11'h5A3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 15'h5A3C, 1'b1, 0, 1'b0, 1'b1, 4'h0, 11'h000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 15'h0001, 1'b1, 0, 1'b0, 1'b1, 4'h1, 11'h000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 15'h5A3C, 1'b1, 0, 1'b0, 1'b1, 4'h0, 11'h000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 15'h0000, 1'b1, 0, 1'b0, 1'b1, 4'h0, 11'h000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 15'h7FFF, 1'b0, 0, 1'b0, 1'b1, 4'h0, 11'h000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 15'h5A3C, 1'b0, 0, 1'b0, 1'b0, 4'h0, 11'h000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 15'h5A3C, 1'b0, 1, 1'b1, 1'b1, 4'hC, 11'h5A3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 15'h7FFF, 1'b1, 0, 1'b1, 1'b0, 4'hC, 11'h5A3, 1'b1, 1'b0, 1'b0});

    // Reset state, sampled while reset is held.
    #3;
    check_outputs(4'h0, 11'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      if (vecs[v].do_reset) begin
        do_reset();
        if (v == 6) check("blocked_cleared", {31'd0, blocked}, 32'd0);
      end
      run_load(vecs[v].key, vecs[v].par, vecs[v].gap_mode, vecs[v].mid_start, vecs[v].exp_ready);
      check_outputs(vecs[v].exp_mux, vecs[v].exp_xor, vecs[v].exp_loaded,
                    vecs[v].exp_error, vecs[v].exp_blocked);
    end

    // Blocked loader must drop blocked on an async reset without a clock edge.
    do_reset();
    for (int i = 0; i < 3; i++) run_load(15'h0000, 1'b1, 0, 1'b0, 1'b1);
    check("blocked_set", {31'd0, blocked}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("blocked_async_clr", {31'd0, blocked}, 32'd0);
    check("key_error_async_clr", {31'd0, key_error}, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Reset mid-load: 7 bits in, then async reset; partial key is discarded.
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_midload", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("bit_ready_async", {31'd0, bit_ready}, 32'd0);
    check("busy_async", {31'd0, busy}, 32'd0);
    check_outputs(4'h0, 11'h000, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_load(15'h5A3C, 1'b0, 0, 1'b0, 1'b1);
    check_outputs(4'hC, 11'h5A3, 1'b1, 1'b0, 1'b0);

    // Randomized loads against the model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      logic [14:0] k;
      logic        p;
      logic        acc;
      if ($urandom_range(0, 7) == 0) do_reset();
      k = 15'($urandom);
      p = ($urandom_range(0, 9) < 7) ? ~(^k) : (^k);
      acc = !(m_loaded || m_blocked);
      run_load(k, p, int'($urandom_range(0, 2)), 1'($urandom), acc);
      model_load(k, p);
      check_outputs(m_mux, m_xor, m_loaded, m_error, m_blocked);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
